// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues word-aligned, byte-masked data-cache requests,
// stalls the pipeline while an access is outstanding and formats returned load data.
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              dcache_read,
    output logic              dcache_write,
    output logic [ADDR_W-1:0] dcache_address,
    output logic [XLEN-1:0]   dcache_wdata,
    output logic [3:0]        dcache_mbe,
    input  logic [XLEN-1:0]   dcache_rdata,
    input  logic              dcache_resp,
    output logic              mem_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              load_valid,
    output logic              misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [2:0]          r_funct3;
    logic                r_is_read;
    logic [XLEN-1:0]     r_load_data;
    logic                w_req;
    logic                w_mis;
    logic                w_accept;

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. undefined codes) word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off,
                                             input logic is_read);
        if (is_read)
            lane_mask = 4'b1111;
        else begin
            case (size)
                2'b00:   lane_mask = 4'b0001 << off;
                2'b01:   lane_mask = 4'b0011 << off;
                default: lane_mask = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [XLEN-1:0] format_load(input logic [2:0] f3, input logic [1:0] off,
                                                    input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b100:  format_load = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b001:  format_load = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b101:  format_load = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: format_load = rdata;
        endcase
    endfunction

    assign w_req    = req_read | req_write;
    assign w_mis    = is_misaligned(funct3[1:0], addr[1:0]);
    assign w_accept = w_req & ~w_mis;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= '0;
            r_is_read   <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            // Read wins when both strobes arrive together; the write is dropped.
            if (r_state == S_IDLE && w_accept) begin
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_funct3  <= funct3;
                r_is_read <= req_read;
            end
            if (r_state == S_ACCESS && dcache_resp && r_is_read)
                r_load_data <= format_load(r_funct3, r_addr[1:0], dcache_rdata);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_ACCESS;
            S_ACCESS: if (dcache_resp) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        dcache_mbe     = 4'b0000;
        mem_stall      = 1'b0;
        load_valid     = 1'b0;
        misaligned     = 1'b0;
        case (r_state)
            S_IDLE: begin
                misaligned = w_req & w_mis;
                mem_stall  = w_accept;
            end
            S_ACCESS: begin
                dcache_read    = r_is_read;
                dcache_write   = ~r_is_read;
                dcache_address = {r_addr[ADDR_W-1:2], 2'b00};
                dcache_wdata   = r_wdata << {r_addr[1:0], 3'b000};
                dcache_mbe     = lane_mask(r_funct3[1:0], r_addr[1:0], r_is_read);
                mem_stall      = 1'b1;
            end
            S_DONE:   load_valid = r_is_read;
            default: ;
        endcase
    end

    assign load_data = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives inputs 1 ns after each rising edge
// and checks outputs on the falling edge against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        dcache_read, dcache_write;
    logic [31:0] dcache_address, dcache_wdata;
    logic [3:0]  dcache_mbe;
    logic [31:0] dcache_rdata;
    logic        dcache_resp;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        load_valid, misaligned;

    int n_assert = 0;
    int n_fail   = 0;

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_mbe(dcache_mbe), .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Load with response in the first ACCESS cycle; checks issue and DONE result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input logic [31:0] exp);
        cyc(); req_read = 1'b1; req_write = 1'b0; funct3 = f3; addr = a;
        smp(); chk({tag, "_idle_stall"}, mem_stall, 1);
        cyc(); dcache_resp = 1'b1; dcache_rdata = rd;
        smp(); chk({tag, "_rd"}, dcache_read, 1);
        chk({tag, "_mbe"}, dcache_mbe, 4'b1111);
        chk({tag, "_addr"}, dcache_address, {a[31:2], 2'b00});
        cyc(); dcache_resp = 1'b0; req_read = 1'b0;
        smp(); chk({tag, "_valid"}, load_valid, 1);
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_done_stall"}, mem_stall, 0);
    endtask

    initial begin
        rst = 1'b0; req_read = 1'b0; req_write = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; dcache_rdata = '0; dcache_resp = 1'b0;
        cyc(); cyc();
        smp();
        chk("rst_read", dcache_read, 0);
        chk("rst_write", dcache_write, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_valid", load_valid, 0);
        chk("rst_mis", misaligned, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_mbe", dcache_mbe, 0);
        cyc(); rst = 1'b1;

        // sb at 0x1003, response on the third ACCESS cycle
        cyc(); req_write = 1'b1; funct3 = 3'b000; addr = 32'h1003; wdata = 32'h0000_00AB;
        smp(); chk("sb_stall0", mem_stall, 1); chk("sb_idle_wr", dcache_write, 0);
        cyc();
        smp(); chk("sb_stall1", mem_stall, 1); chk("sb_wr", dcache_write, 1);
        chk("sb_rd", dcache_read, 0);
        chk("sb_addr", dcache_address, 32'h1000);
        chk("sb_mbe", dcache_mbe, 4'b1000);
        chk("sb_wdata", dcache_wdata, 32'hAB00_0000);
        cyc();
        smp(); chk("sb_stall2", mem_stall, 1);
        cyc(); dcache_resp = 1'b1;
        smp(); chk("sb_stall3", mem_stall, 1); chk("sb_wr3", dcache_write, 1);
        cyc(); dcache_resp = 1'b0; req_write = 1'b0;
        smp(); chk("sb_done_stall", mem_stall, 0); chk("sb_done_valid", load_valid, 0);
        chk("sb_done_wr", dcache_write, 0);
        cyc();
        smp(); chk("sb_idle_stall", mem_stall, 0); chk("sb_idle_valid", load_valid, 0);

        do_load("lb",  3'b000, 32'h2002, 32'h0080_FF00, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h2002, 32'h0080_FF00, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h2002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h2002, 32'h8001_1234, 32'h0000_8001);
        do_load("lb0", 3'b000, 32'h2000, 32'h0000_007F, 32'h0000_007F);
        do_load("lundef", 3'b011, 32'h2004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // misaligned lw
        cyc(); req_read = 1'b1; funct3 = 3'b010; addr = 32'h2001;
        smp(); chk("mis_flag", misaligned, 1); chk("mis_stall", mem_stall, 0);
        chk("mis_rd", dcache_read, 0);
        cyc(); req_read = 1'b0;
        smp(); chk("mis_flag_off", misaligned, 0); chk("mis_rd2", dcache_read, 0);
        chk("mis_ldata_held", load_data, 32'hCAFE_F00D);

        // misaligned lh (odd address)
        cyc(); req_read = 1'b1; funct3 = 3'b001; addr = 32'h2003;
        smp(); chk("mish_flag", misaligned, 1); chk("mish_stall", mem_stall, 0);
        cyc(); req_read = 1'b0;

        // reset in the second ACCESS cycle; late response must be ignored
        cyc(); req_read = 1'b1; funct3 = 3'b010; addr = 32'h3000;
        smp(); chk("rs_stall0", mem_stall, 1);
        cyc();
        smp(); chk("rs_rd1", dcache_read, 1);
        cyc(); rst = 1'b0;
        smp(); chk("rs_rd2", dcache_read, 1);
        cyc(); rst = 1'b1; dcache_resp = 1'b1; dcache_rdata = 32'h1111_2222; req_read = 1'b0;
        smp(); chk("rs_rd_after", dcache_read, 0); chk("rs_wr_after", dcache_write, 0);
        chk("rs_stall_after", mem_stall, 0); chk("rs_valid_after", load_valid, 0);
        cyc(); dcache_resp = 1'b0;
        smp(); chk("rs_valid_late", load_valid, 0); chk("rs_ldata", load_data, 0);
        chk("rs_stall_late", mem_stall, 0);

        // lw then sw back-to-back
        cyc(); req_read = 1'b1; funct3 = 3'b010; addr = 32'h4000;
        smp(); chk("bb_lw_stall0", mem_stall, 1);
        cyc(); dcache_resp = 1'b1; dcache_rdata = 32'hDEAD_BEEF;
        smp(); chk("bb_lw_stall1", mem_stall, 1); chk("bb_lw_rd", dcache_read, 1);
        cyc(); dcache_resp = 1'b0;
        smp(); chk("bb_done_stall", mem_stall, 0); chk("bb_done_valid", load_valid, 1);
        chk("bb_done_data", load_data, 32'hDEAD_BEEF); chk("bb_done_rd", dcache_read, 0);
        cyc(); req_read = 1'b0; req_write = 1'b1; addr = 32'h4004; wdata = 32'h1234_5678;
        smp(); chk("bb_sw_stall0", mem_stall, 1); chk("bb_sw_idle_wr", dcache_write, 0);
        chk("bb_sw_idle_valid", load_valid, 0);
        cyc(); dcache_resp = 1'b1;
        smp(); chk("bb_sw_stall1", mem_stall, 1); chk("bb_sw_wr", dcache_write, 1);
        chk("bb_sw_addr", dcache_address, 32'h4004);
        chk("bb_sw_mbe", dcache_mbe, 4'b1111);
        chk("bb_sw_wdata", dcache_wdata, 32'h1234_5678);
        cyc(); dcache_resp = 1'b0; req_write = 1'b0;
        smp(); chk("bb_sw_done_stall", mem_stall, 0); chk("bb_sw_done_valid", load_valid, 0);
        chk("bb_sw_ldata_held", load_data, 32'hDEAD_BEEF);

        // sh at 0x6002
        cyc(); req_write = 1'b1; funct3 = 3'b001; addr = 32'h6002; wdata = 32'h0000_BEEF;
        cyc(); dcache_resp = 1'b1;
        smp(); chk("sh_mbe", dcache_mbe, 4'b1100); chk("sh_wdata", dcache_wdata, 32'hBEEF_0000);
        chk("sh_addr", dcache_address, 32'h6000);
        cyc(); dcache_resp = 1'b0; req_write = 1'b0;

        // read and write together: read wins
        cyc(); req_read = 1'b1; req_write = 1'b1; funct3 = 3'b001; addr = 32'h5002;
        cyc(); dcache_resp = 1'b1; dcache_rdata = 32'h7FFF_0000;
        smp(); chk("both_rd", dcache_read, 1); chk("both_wr", dcache_write, 0);
        chk("both_mbe", dcache_mbe, 4'b1111);
        cyc(); dcache_resp = 1'b0; req_read = 1'b0; req_write = 1'b0;
        smp(); chk("both_valid", load_valid, 1); chk("both_data", load_data, 32'h0000_7FFF);

        // stray response in IDLE is ignored
        cyc(); dcache_resp = 1'b1; dcache_rdata = 32'h5555_5555;
        smp(); chk("stray_stall", mem_stall, 0);
        cyc(); dcache_resp = 1'b0;
        smp(); chk("stray_valid", load_valid, 0); chk("stray_ldata", load_data, 32'h0000_7FFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
